// File: rtl/inst_loader_pkg.sv
// ============================================================================
// Module      : inst_loader_pkg
// Description : Shared types and constants for the instruction memory loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package inst_loader_pkg;

  localparam int          BYTES_PER_WORD  = 4;
  localparam int          WORD_BYTES_LOG2 = 2;
  localparam int          LEN_W           = 16;
  localparam logic [31:0] ADDR_STEP       = 32'd4;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_HI = 3'd1,
    S_LEN_LO = 3'd2,
    S_DATA   = 3'd3,
    S_CHK    = 3'd4,
    S_DONE   = 3'd5,
    S_ERROR  = 3'd6
  } state_t;

endpackage

`default_nettype wire

// File: rtl/inst_loader_byte_assembler.sv
// ============================================================================
// Module      : byte_assembler
// Description : Shifts accepted bytes MSB-first into 32-bit words and emits a
//               one-cycle word_valid pulse alongside each completed word.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module byte_assembler
  import inst_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clear,
  input  logic        i_byte_en,
  input  logic [7:0]  i_byte,
  output logic        o_word_end,
  output logic        o_word_valid,
  output logic [31:0] o_word
);

  localparam logic [WORD_BYTES_LOG2-1:0] c_LAST_BYTE = WORD_BYTES_LOG2'(BYTES_PER_WORD - 1);

  logic [8*(BYTES_PER_WORD-1)-1:0] r_shift;
  logic [WORD_BYTES_LOG2-1:0]      r_cnt;
  logic                            r_word_valid;
  logic [31:0]                     r_word;

  // High on the handshake that carries the last byte of a word.
  assign o_word_end   = i_byte_en && (r_cnt == c_LAST_BYTE);
  assign o_word_valid = r_word_valid;
  assign o_word       = r_word;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift      <= '0;
      r_cnt        <= '0;
      r_word_valid <= 1'b0;
      r_word       <= '0;
    end else begin
      r_word_valid <= 1'b0;
      if (i_clear) begin
        r_shift <= '0;
        r_cnt   <= '0;
      end else if (i_byte_en) begin
        if (r_cnt == c_LAST_BYTE) begin
          r_word       <= {r_shift, i_byte};
          r_word_valid <= 1'b1;
          r_cnt        <= '0;
        end else begin
          r_shift <= {r_shift[8*(BYTES_PER_WORD-2)-1:0], i_byte};
          r_cnt   <= r_cnt + 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/inst_loader.sv
// ============================================================================
// Module      : inst_loader
// Description : Boot-time loader that fills the instruction memory from a
//               length-prefixed big-endian byte stream and holds the CPU
//               until the load completes. Define INST_LOADER_CHECKSUM_EN to
//               require a trailing XOR checksum byte.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_loader
  import inst_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [7:0]       i_rx_data,
  input  logic             i_rx_valid,
  output logic             o_rx_ready,
  output logic             o_mem_we,
  output logic [31:0]      o_mem_addr,
  output logic [31:0]      o_mem_wdata,
  output logic             o_cpu_hold,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err,
  output logic [LEN_W-1:0] o_word_count
);

  state_t           r_state;
  logic             r_rx_ready;
  logic [31:0]      r_mem_addr;
  logic             r_cpu_hold;
  logic             r_busy;
  logic             r_done;
  logic             r_err;
  logic [LEN_W-1:0] r_word_count;
  logic [LEN_W-1:0] r_len;

  logic             w_acc;
  logic             w_start_ok;
  logic [LEN_W-1:0] w_len;
  logic             w_len_too_big;
  logic             w_word_end;
  logic             w_mem_we;
  logic [31:0]      w_word;

  assign w_acc         = i_rx_valid && r_rx_ready;
  assign w_start_ok    = i_start && ((r_state == S_IDLE) || (r_state == S_DONE) ||
                                     (r_state == S_ERROR));
  assign w_len         = {r_len[LEN_W-1:8], i_rx_data};
  assign w_len_too_big = 32'(w_len) > MAX_WORDS;

  byte_assembler u_asm (
    .clk          (clk),
    .rst          (rst),
    .i_clear      (w_start_ok),
    .i_byte_en    (w_acc && (r_state == S_DATA)),
    .i_byte       (i_rx_data),
    .o_word_end   (w_word_end),
    .o_word_valid (w_mem_we),
    .o_word       (w_word)
  );

`ifdef INST_LOADER_CHECKSUM_EN
  logic [7:0] r_xor;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_xor <= '0;
    end else if (w_start_ok) begin
      r_xor <= '0;
    end else if (w_acc && (r_state == S_DATA)) begin
      r_xor <= r_xor ^ i_rx_data;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_rx_ready   <= 1'b0;
      r_mem_addr   <= BASE_ADDR;
      r_cpu_hold   <= 1'b1;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_word_count <= '0;
      r_len        <= '0;
    end else if (w_start_ok) begin
      r_state      <= S_LEN_HI;
      r_rx_ready   <= 1'b1;
      r_mem_addr   <= BASE_ADDR;
      r_cpu_hold   <= 1'b1;
      r_busy       <= 1'b1;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_word_count <= '0;
    end else begin
      case (r_state)
        S_LEN_HI: begin
          if (w_acc) begin
            r_len[LEN_W-1:8] <= i_rx_data;
            r_state          <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (w_acc) begin
            r_len <= w_len;
            if (w_len == '0) begin
              r_state    <= S_DONE;
              r_rx_ready <= 1'b0;
              r_busy     <= 1'b0;
              r_done     <= 1'b1;
              r_cpu_hold <= 1'b0;
            end else if (w_len_too_big) begin
              r_state    <= S_ERROR;
              r_rx_ready <= 1'b0;
              r_busy     <= 1'b0;
              r_err      <= 1'b1;
            end else begin
              r_state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (w_mem_we) begin
            r_mem_addr <= r_mem_addr + ADDR_STEP;
          end
          // Stop accepting after the last word; stay one cycle for its write pulse.
          if (w_word_end) begin
            r_word_count <= r_word_count + 16'd1;
            if ((r_word_count + 16'd1) == r_len) begin
              r_rx_ready <= 1'b0;
            end
          end
          if (!r_rx_ready) begin
`ifdef INST_LOADER_CHECKSUM_EN
            r_state    <= S_CHK;
            r_rx_ready <= 1'b1;
`else
            r_state    <= S_DONE;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_cpu_hold <= 1'b0;
`endif
          end
        end
`ifdef INST_LOADER_CHECKSUM_EN
        S_CHK: begin
          if (w_acc) begin
            r_rx_ready <= 1'b0;
            r_busy     <= 1'b0;
            if (i_rx_data == r_xor) begin
              r_state    <= S_DONE;
              r_done     <= 1'b1;
              r_cpu_hold <= 1'b0;
            end else begin
              r_state <= S_ERROR;
              r_err   <= 1'b1;
            end
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign o_rx_ready   = r_rx_ready;
  assign o_mem_we     = w_mem_we;
  assign o_mem_addr   = r_mem_addr;
  assign o_mem_wdata  = w_word;
  assign o_cpu_hold   = r_cpu_hold;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_err        = r_err;
  assign o_word_count = r_word_count;

endmodule

`default_nettype wire
